torreta_uc: RTL and testbench

Control unit for the turret. It sequences the `torreta_fd` datapath through one scan step: measure, transmit, evaluate the threat, fire if needed, wait, then rotate. It drives every datapath command input and consumes every datapath status output. It also synchronizes the ammo-load button before passing it to the datapath.

---
 rtl/torreta_pkg.sv | 25 ++
 rtl/torreta_uc_sincronizador_2ff.sv | 25 ++
 rtl/torreta_uc.sv | 141 ++++++++++++++
 tb/tb_torreta_uc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/torreta_pkg.sv
// torreta_pkg: shared definitions for the turret control unit and datapath.
//   - state codes of the torreta_uc FSM (also exported on db_estado)
//   - default watchdog parameters (50 ms at 50 MHz)
//   - distancia_max_ameaca: threat distance threshold used by the datapath
package torreta_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_MEDIR          = 4'h2;
  localparam logic [3:0] ST_AGUARDA_MEDIDA = 4'h3;
  localparam logic [3:0] ST_TRANSMITIR     = 4'h4;
  localparam logic [3:0] ST_AGUARDA_ENVIO  = 4'h5;
  localparam logic [3:0] ST_AVALIA         = 4'h6;
  localparam logic [3:0] ST_ARMAR          = 4'h7;
  localparam logic [3:0] ST_DISPARO        = 4'h8;
  localparam logic [3:0] ST_RECARGA        = 4'h9;
  localparam logic [3:0] ST_ESPERA_GIRO    = 4'hA;
  localparam logic [3:0] ST_GIRAR          = 4'hB;

  localparam int TIMEOUT_PADRAO   = 2_500_000;
  localparam int N_TIMEOUT_PADRAO = 22;

  localparam logic [8:0] distancia_max_ameaca = 9'd50;

endpackage

// File: rtl/torreta_uc_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchronizer for a single asynchronous level.
//   clock : destination clock
//   reset : asynchronous active-low clear of both flops
//   d     : asynchronous input
//   q     : synchronized output (2 clock latency)
module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/torreta_uc.sv
// torreta_uc: control unit of the turret. Sequences torreta_fd through one
// scan step (measure, transmit, evaluate, fire if needed, wait, rotate).
//   clock, reset          : system clock / async active-low reset
//   ligar                 : run enable level
//   carregar              : raw ammo-load button, synchronized to conta_municao
//   *_pronto, fim_*, ...  : datapath status inputs
//   medir ... recarregar_disparo : datapath command outputs (Moore decoded)
//   pronto                : idle indication
//   db_timeout            : sticky measurement-timeout flag
//   db_estado             : current state code
//
// state | meaning
// 0 inicial        | idle, pronto=1, waits for ligar
// 1 preparacao     | clears measurement watchdog
// 2 medir_st       | 1-cycle measure command
// 3 aguarda_medida | waits for measurement, watchdog running
// 4 transmitir_st  | 1-cycle transmit command
// 5 aguarda_envio  | waits for serial frame sent
// 6 avalia         | threat & ammo decision
// 7 armar          | arming counter enabled
// 8 disparo        | firing counter enabled
// 9 recarga        | reload counter enabled
// A espera_giro    | inter-rotation timer enabled
// B girar_st       | 1-cycle servo step, then next step or idle
module torreta_uc
  import torreta_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_PADRAO,
  parameter int N_TIMEOUT = N_TIMEOUT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       carregar,
  input  logic       medida_pronto,
  input  logic       envio_pronto,
  input  logic       fim_tempo,
  input  logic       ameaca_detectada,
  input  logic       municao_carregada,
  input  logic       disparo_pronto,
  input  logic       fim_disparo,
  input  logic       disparo_carregado,
  output logic       medir,
  output logic       transmitir,
  output logic       girar,
  output logic       conta_tempo,
  output logic       armar_disparo,
  output logic       disparar,
  output logic       recarregar_disparo,
  output logic       conta_municao,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [N_TIMEOUT-1:0] WD_FIM = N_TIMEOUT'(TIMEOUT - 1);

  logic [3:0]           estado, proximo;
  logic [N_TIMEOUT-1:0] watchdog;
  logic                 wd_fim;

  assign wd_fim = (watchdog == WD_FIM);

  sincronizador_2ff u_sinc_carregar (
    .clock (clock),
    .reset (reset),
    .d     (carregar),
    .q     (conta_municao)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= ST_INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = ST_INICIAL;
    case (estado)
      ST_INICIAL:        proximo = ligar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:     proximo = ST_MEDIR;
      ST_MEDIR:          proximo = ST_AGUARDA_MEDIDA;
      // measurement completion wins over a simultaneous watchdog expiry
      ST_AGUARDA_MEDIDA: proximo = medida_pronto ? ST_TRANSMITIR :
                                   wd_fim        ? ST_ESPERA_GIRO : ST_AGUARDA_MEDIDA;
      ST_TRANSMITIR:     proximo = ST_AGUARDA_ENVIO;
      ST_AGUARDA_ENVIO:  proximo = envio_pronto ? ST_AVALIA : ST_AGUARDA_ENVIO;
      ST_AVALIA:         proximo = (ameaca_detectada && municao_carregada) ?
                                   ST_ARMAR : ST_ESPERA_GIRO;
      ST_ARMAR:          proximo = disparo_pronto ? ST_DISPARO : ST_ARMAR;
      ST_DISPARO:        proximo = fim_disparo ? ST_RECARGA : ST_DISPARO;
      ST_RECARGA:        proximo = disparo_carregado ? ST_ESPERA_GIRO : ST_RECARGA;
      ST_ESPERA_GIRO:    proximo = fim_tempo ? ST_GIRAR : ST_ESPERA_GIRO;
      ST_GIRAR:          proximo = ligar ? ST_PREPARACAO : ST_INICIAL;
      default:           proximo = ST_INICIAL;
    endcase
  end

  always_comb begin
    medir              = 1'b0;
    transmitir         = 1'b0;
    girar              = 1'b0;
    conta_tempo        = 1'b0;
    armar_disparo      = 1'b0;
    disparar           = 1'b0;
    recarregar_disparo = 1'b0;
    pronto             = 1'b0;
    case (estado)
      ST_INICIAL:     pronto             = 1'b1;
      ST_MEDIR:       medir              = 1'b1;
      ST_TRANSMITIR:  transmitir         = 1'b1;
      ST_ARMAR:       armar_disparo      = 1'b1;
      ST_DISPARO:     disparar           = 1'b1;
      ST_RECARGA:     recarregar_disparo = 1'b1;
      ST_ESPERA_GIRO: conta_tempo        = 1'b1;
      ST_GIRAR:       girar              = 1'b1;
      default:        ;
    endcase
  end

  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      watchdog <= '0;
    end else if (estado == ST_PREPARACAO) begin
      watchdog <= '0;
    end else if (estado == ST_AGUARDA_MEDIDA) begin
      watchdog <= watchdog + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_timeout <= 1'b0;
    end else if (estado == ST_AGUARDA_MEDIDA) begin
      if (medida_pronto)  db_timeout <= 1'b0;
      else if (wd_fim)    db_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_torreta_uc.sv
module tb_torreta_uc;

  localparam int TO  = 100;
  localparam int NTO = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0, carregar = 1'b0;
  logic       medida_pronto = 1'b0, envio_pronto = 1'b0, fim_tempo = 1'b0;
  logic       ameaca_detectada = 1'b0, municao_carregada = 1'b0;
  logic       disparo_pronto = 1'b0, fim_disparo = 1'b0, disparo_carregado = 1'b0;
  logic       medir, transmitir, girar, conta_tempo, armar_disparo, disparar;
  logic       recarregar_disparo, conta_municao, pronto, db_timeout;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  torreta_uc #(.TIMEOUT(TO), .N_TIMEOUT(NTO)) dut (
    .clock              (clock),
    .reset              (reset),
    .ligar              (ligar),
    .carregar           (carregar),
    .medida_pronto      (medida_pronto),
    .envio_pronto       (envio_pronto),
    .fim_tempo          (fim_tempo),
    .ameaca_detectada   (ameaca_detectada),
    .municao_carregada  (municao_carregada),
    .disparo_pronto     (disparo_pronto),
    .fim_disparo        (fim_disparo),
    .disparo_carregado  (disparo_carregado),
    .medir              (medir),
    .transmitir         (transmitir),
    .girar              (girar),
    .conta_tempo        (conta_tempo),
    .armar_disparo      (armar_disparo),
    .disparar           (disparar),
    .recarregar_disparo (recarregar_disparo),
    .conta_municao      (conta_municao),
    .pronto             (pronto),
    .db_timeout         (db_timeout),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  logic [6:0] cmds;
  assign cmds = {medir, transmitir, girar, conta_tempo, armar_disparo, disparar, recarregar_disparo};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which single command the specification asks for in each state.
  function automatic logic [6:0] cmds_of(input int code);
    case (code)
      2:  return 7'b1000000;
      4:  return 7'b0100000;
      11: return 7'b0010000;
      10: return 7'b0001000;
      7:  return 7'b0000100;
      8:  return 7'b0000010;
      9:  return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check_state(input string tag, input int code);
    chk({tag, " estado"}, 32'(db_estado), 32'(code));
    chk({tag, " cmds"}, 32'(cmds), 32'(cmds_of(code)));
    chk({tag, " pronto"}, 32'(pronto), 32'(code == 0));
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_done(input int code, input logic v);
    case (code)
      3:  medida_pronto     = v;
      5:  envio_pronto      = v;
      7:  disparo_pronto    = v;
      8:  fim_disparo       = v;
      9:  disparo_carregado = v;
      10: fim_tempo         = v;
      default: ;
    endcase
  endtask

  // One scan step, entered at a negedge where preparacao is expected.
  // The expected state path is built from the step's scenario, then walked.
  task automatic run_step(input bit timeout, input bit threat, input bit ammo,
                          input bit ligar_end, input bit abort);
    int path[$];
    int code, dly;
    string tag;
    ameaca_detectada  = threat;
    municao_carregada = ammo;
    path = {1, 2, 3};
    if (!timeout) path = {path, 4, 5, 6};
    if (!timeout && threat && ammo) path = {path, 7, 8, 9};
    path = {path, 10, 11};
    foreach (path[i]) begin
      code = path[i];
      tag  = $sformatf("st%0h", code);
      if (code == 4) chk("timeout_clr", 32'(db_timeout), 32'd0);
      if (code == 10 && timeout) chk("timeout_set", 32'(db_timeout), 32'd1);
      if (code == 3 && timeout) begin
        for (int k = 0; k < TO; k++) begin
          check_state("wd", 3);
          ligar = 1'($urandom_range(0, 1));
          tick();
        end
      end else if (abort && code == 9) begin
        reset = 1'b0;
        #1;
        chk("rst estado", 32'(db_estado), 32'd0);
        chk("rst cmds", 32'(cmds), 32'd0);
        chk("rst pronto", 32'(pronto), 32'd1);
        chk("rst timeout", 32'(db_timeout), 32'd0);
        chk("rst municao", 32'(conta_municao), 32'd0);
        return;
      end else if (abort && code == 8) begin
        carregar = 1'b1;
        for (int k = 0; k < 4; k++) begin
          chk("sync lag", 32'(conta_municao), 32'(k >= 2));
          check_state(tag, 8);
          tick();
        end
        set_done(8, 1'b1);
        check_state(tag, 8);
        tick();
        set_done(8, 1'b0);
      end else if (code inside {3, 5, 7, 8, 9, 10}) begin
        dly = (code == 3) ? $urandom_range(0, 95) : $urandom_range(0, 6);
        for (int k = 0; k < dly; k++) begin
          check_state(tag, code);
          ligar = 1'($urandom_range(0, 1));
          tick();
        end
        set_done(code, 1'b1);
        check_state({tag, " done"}, code);
        tick();
        set_done(code, 1'b0);
      end else begin
        check_state(tag, code);
        if (code == 11) ligar = ligar_end;
        else            ligar = 1'($urandom_range(0, 1));
        tick();
      end
    end
    if (!ligar_end) begin
      dly = $urandom_range(1, 4);
      for (int k = 0; k < dly; k++) begin
        check_state("idle", 0);
        tick();
      end
      ligar = 1'b1;
      check_state("idle go", 0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit t, th, am, le;
    #1;
    chk("reset estado", 32'(db_estado), 32'd0);
    chk("reset cmds", 32'(cmds), 32'd0);
    chk("reset pronto", 32'(pronto), 32'd1);
    chk("reset timeout", 32'(db_timeout), 32'd0);
    chk("reset municao", 32'(conta_municao), 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_state("idle0", 0);
      tick();
    end
    // synchronizer works while idle
    carregar = 1'b1;
    tick();
    chk("idle sync1", 32'(conta_municao), 32'd0);
    tick();
    chk("idle sync2", 32'(conta_municao), 32'd1);
    carregar = 1'b0;
    tick();
    tick();
    chk("idle sync3", 32'(conta_municao), 32'd0);
    ligar = 1'b1;
    tick();

    run_step(0, 0, 0, 1, 0);
    run_step(0, 1, 1, 1, 0);
    run_step(0, 1, 0, 0, 0);
    run_step(1, 0, 0, 1, 0);
    run_step(0, 0, 1, 1, 0);
    run_step(1, 1, 1, 0, 0);
    run_step(0, 1, 1, 1, 0);
    for (int s = 0; s < 12; s++) begin
      t  = ($urandom_range(0, 3) == 0);
      th = 1'($urandom_range(0, 1));
      am = 1'($urandom_range(0, 1));
      le = 1'($urandom_range(0, 1));
      run_step(t, th, am, le, 0);
    end
    run_step(0, 1, 1, 1, 1);
    tick();
    carregar = 1'b0;
    ligar    = 1'b0;
    reset    = 1'b1;
    tick();
    check_state("post rst", 0);
    tick();
    check_state("post rst2", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
